switch_toggle_bank: RTL

//   Multi-channel switch front end for the board. Each of NUM_CH switch inputs is

---
 rtl/switch_toggle_bank_if.sv | 21 ++
 rtl/switch_toggle_bank.sv | 78 +++++++
 2 files changed

// File: rtl/switch_toggle_bank_if.sv
// Switch/LED bundle for switch_toggle_bank: raw switch levels and clear in, debounced
// levels, edge pulses and toggle states out.
interface switch_toggle_bank_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] i_Switch;
  logic              i_Clear;
  logic [NUM_CH-1:0] o_Switch_Stable;
  logic [NUM_CH-1:0] o_Edge_Pulse;
  logic [NUM_CH-1:0] o_LED;

  modport master (
    output i_Switch, i_Clear,
    input  o_Switch_Stable, o_Edge_Pulse, o_LED
  );

  modport slave (
    input  i_Switch, i_Clear,
    output o_Switch_Stable, o_Edge_Pulse, o_LED
  );
endinterface

// File: rtl/switch_toggle_bank.sv
// Per-channel switch synchroniser + debouncer + edge detector driving a toggling LED
// and a one-cycle edge pulse; all channels independent except the shared clear.
module switch_toggle_bank #(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_MODE       = 0
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  switch_toggle_bank_if.slave  bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
  logic [CW-1:0]          cnt_q  [NUM_CH];
  logic [NUM_CH-1:0]      stable_q;
  logic [NUM_CH-1:0]      pulse_q;
  logic [NUM_CH-1:0]      led_q;

  logic [NUM_CH-1:0]      synced;
  logic [NUM_CH-1:0]      accept;
  logic [NUM_CH-1:0]      qual;

  always_comb begin
    synced = '0;
    accept = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      synced[ch] = sync_q[ch][SYNC_STAGES-1];
      accept[ch] = (synced[ch] != stable_q[ch]) && (cnt_q[ch] == CNT_LAST);
    end
  end

  // An accept flips stable, so the pre-accept stable level gives the edge direction.
  always_comb begin
    qual = '0;
    if (EDGE_MODE == 0)
      qual = accept & stable_q;
    else if (EDGE_MODE == 1)
      qual = accept & ~stable_q;
    else
      qual = accept;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        sync_q[ch] <= '0;
        cnt_q[ch]  <= '0;
      end
      stable_q <= '0;
      pulse_q  <= '0;
      led_q    <= '0;
    end else begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], bus.i_Switch[ch]};
        if (synced[ch] == stable_q[ch]) begin
          cnt_q[ch] <= '0;
        end else if (accept[ch]) begin
          cnt_q[ch]    <= '0;
          stable_q[ch] <= synced[ch];
        end else begin
          cnt_q[ch] <= cnt_q[ch] + CNT_ONE;
        end
      end
      pulse_q <= qual;
      led_q   <= bus.i_Clear ? '0 : (led_q ^ qual);
    end
  end

  assign bus.o_Switch_Stable = stable_q;
  assign bus.o_Edge_Pulse    = pulse_q;
  assign bus.o_LED           = led_q;

endmodule
